codificador_hamming_tx: RTL and testbench
=========================================

CODIFICADOR_HAMMING_TX -- requirements
Module: codificador_hamming_tx

Interface
REQ-001 Parameter CICLOS_POR_BIT, default 1, number of reloj cycles each serial bit is held (legal range 1..255).
REQ-002 reloj  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dato  input  4  data nibble to encode.
REQ-005 dato_valido  input  1  producer asserts when dato is valid.
REQ-006 listo  output  1  block can accept a nibble.
REQ-007 inyectar_simple  input  1  flip one codeword bit at acceptance (test aid).
REQ-008 inyectar_doble  input  1  flip two codeword bits at acceptance (test aid).
REQ-009 pos_error  input  3  bit index for injection.
REQ-010 palabra  output  8  registered transmitted codeword, held until the next acceptance.
REQ-011 tx_bit  output  1  serial codeword bit.
REQ-012 tx_valido  output  1  tx_bit is meaningful.
REQ-013 tx_inicio  output  1  high during the bit-0 period of each frame.
REQ-014 tx_fin  output  1  one-cycle pulse after the last bit.

Function
REQ-015 Codeword layout: data bits dato[0..3] at palabra bits 3,5,6,7; parity bits at bits 1,2,4; overall parity at bit 0.
REQ-016 Parity (even): bit1 = b3^b5^b7, bit2 = b3^b6^b7, bit4 = b5^b6^b7, bit0 = XOR of bits 1..7.
REQ-017 Handshake: the block accepts a nibble on a rising edge where dato_valido=1 and listo=1; dato is ignored at all other times.
REQ-018 The FSM has three states: REPOSO (listo=1), ENVIO, FIN; accept moves REPOSO->ENVIO, completing the last bit moves ENVIO->FIN, and FIN->REPOSO always follows after one cycle.
REQ-019 On acceptance, palabra loads the encoded word, XOR-ed with the injection mask sampled on the same edge.
REQ-020 Injection mask: inyectar_doble=1 flips pos_error and (pos_error+1) mod 8 (wrap-around: 7 pairs with 0); else inyectar_simple=1 flips pos_error only; both 0 gives no flip; doble takes priority.
REQ-021 Serialization is LSB first (bit0..bit7); each bit is held CICLOS_POR_BIT cycles; the frame lasts 8*CICLOS_POR_BIT cycles.
REQ-022 Latency: tx_valido=1 and tx_bit=palabra[0] in the first cycle after the acceptance edge.
REQ-023 tx_valido=1 only in ENVIO; tx_bit=0 whenever tx_valido=0.
REQ-024 tx_fin=1 only in FIN; listo=0 in ENVIO and FIN, so back-to-back frames are separated by a minimum 1-cycle gap.
REQ-025 Changes to dato or to the injection inputs during ENVIO do not affect the frame in flight.
REQ-026 The bit counter is 3 bits and the cycle counter is 8 bits; both clear on every acceptance.

Reset
REQ-027 Reset asserted (including mid-frame): FSM=REPOSO, listo=1, palabra=8'h00, tx_bit=0, tx_valido=0, tx_inicio=0, tx_fin=0, counters=0.
REQ-028 An aborted frame is not resumed; the first acceptance after reset release starts a fresh frame.

Structure
REQ-029 The shared package holds the FSM state enum, the codeword bit-position constants (data and parity indices), and the width constants 4 and 8.
REQ-030 One combinational sub-module, generador_paridad (4-bit in, 8-bit codeword out), is instantiated once; sequencing stays in the top module.

Verification
REQ-031 With CICLOS_POR_BIT=1: dato=4'b1011 accepted -> palabra=8'hAA; tx_bit sequence 0,1,0,1,0,1,0,1 over 8 cycles; tx_fin pulses in cycle 9.
REQ-032 dato=4'h0 -> palabra=8'h00; dato=4'hF -> palabra=8'hFF.
REQ-033 dato=4'b1011 with inyectar_simple=1 and pos_error=2 -> palabra=8'hAE; dato=4'h0 with inyectar_doble=1 and pos_error=7 -> palabra=8'h81 (wrap).
REQ-034 With CICLOS_POR_BIT=3: each bit is held 3 cycles; tx_inicio is high for 3 cycles; the frame lasts 24 cycles; dato toggled mid-frame -> serial output unchanged.
REQ-035 reset pulsed at frame bit 4 -> all outputs reach reset values asynchronously; a new nibble is accepted on the first edge after release.
REQ-036 Loopback: every nibble 0..15 with no injection through Correccion_de_error -> corrected data equals the input with no error flags; with single injection -> error_simple flagged and data recovered; with double injection -> error_doble flagged.

Source files
------------

// File: rtl/codificador_hamming_tx_pkg.sv
// Shared types and constants for the Hamming(8,4) SECDED serial transmitter.
package codificador_hamming_tx_pkg;

  localparam int unsigned ANCHO_DATO    = 4;
  localparam int unsigned ANCHO_PALABRA = 8;
  localparam int unsigned ANCHO_POS     = 3;
  localparam int unsigned ANCHO_CICLO   = 8;

  // Data bit positions inside the codeword (dato[0..3])
  localparam int unsigned POS_D0 = 3;
  localparam int unsigned POS_D1 = 5;
  localparam int unsigned POS_D2 = 6;
  localparam int unsigned POS_D3 = 7;

  // Hamming parity positions and overall parity position
  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_PG = 0;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ENVIO  = 2'd1,
    FIN    = 2'd2
  } estado_t;

endpackage

// File: rtl/codificador_hamming_tx_generador_paridad.sv
// Combinational Hamming(8,4) encoder with overall even parity in bit 0.
module generador_paridad
  import codificador_hamming_tx_pkg::*;
(
  input  logic [ANCHO_DATO-1:0]    i_dato,
  output logic [ANCHO_PALABRA-1:0] o_palabra
);

  logic [ANCHO_PALABRA-1:0] w_sin_pg;

  // Place data bits, then derive the three Hamming parities
  always_comb begin
    w_sin_pg         = '0;
    w_sin_pg[POS_D0] = i_dato[0];
    w_sin_pg[POS_D1] = i_dato[1];
    w_sin_pg[POS_D2] = i_dato[2];
    w_sin_pg[POS_D3] = i_dato[3];
    w_sin_pg[POS_P1] = i_dato[0] ^ i_dato[1] ^ i_dato[3];
    w_sin_pg[POS_P2] = i_dato[0] ^ i_dato[2] ^ i_dato[3];
    w_sin_pg[POS_P4] = i_dato[1] ^ i_dato[2] ^ i_dato[3];
  end

  // Overall parity covers bits 1..7 so the full word has even parity
  always_comb begin
    o_palabra         = w_sin_pg;
    o_palabra[POS_PG] = ^w_sin_pg[ANCHO_PALABRA-1:1];
  end

endmodule

// File: rtl/codificador_hamming_tx.sv
// Hamming(8,4) SECDED encoder with error injection and LSB-first serializer.
module codificador_hamming_tx
  import codificador_hamming_tx_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BIT = 1
) (
  input  logic                     reloj,
  input  logic                     reset,
  input  logic [ANCHO_DATO-1:0]    dato,
  input  logic                     dato_valido,
  output logic                     listo,
  input  logic                     inyectar_simple,
  input  logic                     inyectar_doble,
  input  logic [ANCHO_POS-1:0]     pos_error,
  output logic [ANCHO_PALABRA-1:0] palabra,
  output logic                     tx_bit,
  output logic                     tx_valido,
  output logic                     tx_inicio,
  output logic                     tx_fin
);

  localparam logic [ANCHO_CICLO-1:0] CICLO_ULT = ANCHO_CICLO'(CICLOS_POR_BIT - 1);
  localparam logic [ANCHO_POS-1:0]   BIT_ULT   = ANCHO_POS'(ANCHO_PALABRA - 1);

  estado_t                  r_estado;
  logic                     r_listo;
  logic [ANCHO_PALABRA-1:0] r_palabra;
  logic                     r_tx_bit;
  logic                     r_tx_valido;
  logic                     r_tx_inicio;
  logic                     r_tx_fin;
  logic [ANCHO_POS-1:0]     r_bit;
  logic [ANCHO_CICLO-1:0]   r_ciclo;

  logic [ANCHO_PALABRA-1:0] w_codigo;
  logic [ANCHO_PALABRA-1:0] w_mascara;
  logic [ANCHO_PALABRA-1:0] w_palabra_tx;
  logic [ANCHO_POS-1:0]     w_pos_par;
  logic                     w_acepta;

  generador_paridad u_generador_paridad (
    .i_dato    (dato),
    .o_palabra (w_codigo)
  );

  // Injection mask: double flips pos and its wrap-around neighbour, double wins
  always_comb begin
    w_mascara = '0;
    w_pos_par = pos_error + 3'd1;
    if (inyectar_doble) begin
      w_mascara[pos_error] = 1'b1;
      w_mascara[w_pos_par] = 1'b1;
    end else if (inyectar_simple) begin
      w_mascara[pos_error] = 1'b1;
    end
  end

  assign w_palabra_tx = w_codigo ^ w_mascara;
  assign w_acepta     = dato_valido && r_listo;

  // Frame sequencer: REPOSO -> ENVIO (8 bits) -> FIN -> REPOSO
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      r_estado    <= REPOSO;
      r_listo     <= 1'b1;
      r_palabra   <= '0;
      r_tx_bit    <= 1'b0;
      r_tx_valido <= 1'b0;
      r_tx_inicio <= 1'b0;
      r_tx_fin    <= 1'b0;
      r_bit       <= '0;
      r_ciclo     <= '0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (w_acepta) begin
            r_estado    <= ENVIO;
            r_listo     <= 1'b0;
            r_palabra   <= w_palabra_tx;
            r_tx_bit    <= w_palabra_tx[0];
            r_tx_valido <= 1'b1;
            r_tx_inicio <= 1'b1;
            r_bit       <= '0;
            r_ciclo     <= '0;
          end
        end
        ENVIO: begin
          if (r_ciclo == CICLO_ULT) begin
            r_ciclo <= '0;
            if (r_bit == BIT_ULT) begin
              r_estado    <= FIN;
              r_tx_bit    <= 1'b0;
              r_tx_valido <= 1'b0;
              r_tx_inicio <= 1'b0;
              r_tx_fin    <= 1'b1;
            end else begin
              r_bit       <= r_bit + 3'd1;
              r_tx_bit    <= r_palabra[r_bit + 3'd1];
              r_tx_inicio <= 1'b0;
            end
          end else begin
            r_ciclo <= r_ciclo + 8'd1;
          end
        end
        FIN: begin
          r_estado <= REPOSO;
          r_tx_fin <= 1'b0;
          r_listo  <= 1'b1;
        end
        default: begin
          r_estado <= REPOSO;
          r_listo  <= 1'b1;
        end
      endcase
    end
  end

  assign listo     = r_listo;
  assign palabra   = r_palabra;
  assign tx_bit    = r_tx_bit;
  assign tx_valido = r_tx_valido;
  assign tx_inicio = r_tx_inicio;
  assign tx_fin    = r_tx_fin;

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Scoreboard bench for codificador_hamming_tx at 1 and 3 cycles per bit.
module tb_codificador_hamming_tx;

  logic       reloj;
  logic       reset;
  logic [3:0] dato;
  logic       dato_valido;
  logic       iny_s;
  logic       iny_d;
  logic [2:0] pos;

  logic       listo1, txb1, txv1, txi1, txf1;
  logic [7:0] palabra1;
  logic       listo3, txb3, txv3, txi3, txf3;
  logic [7:0] palabra3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q1[$];
  logic [7:0] q3[$];

  int         m_cnt [2];
  logic [7:0] m_word[2];
  logic       m_finp[2];
  logic       m_gap [2];

  codificador_hamming_tx #(.CICLOS_POR_BIT(1)) dut1 (
    .reloj(reloj), .reset(reset), .dato(dato), .dato_valido(dato_valido),
    .listo(listo1), .inyectar_simple(iny_s), .inyectar_doble(iny_d),
    .pos_error(pos), .palabra(palabra1), .tx_bit(txb1), .tx_valido(txv1),
    .tx_inicio(txi1), .tx_fin(txf1)
  );

  codificador_hamming_tx #(.CICLOS_POR_BIT(3)) dut3 (
    .reloj(reloj), .reset(reset), .dato(dato), .dato_valido(dato_valido),
    .listo(listo3), .inyectar_simple(iny_s), .inyectar_doble(iny_d),
    .pos_error(pos), .palabra(palabra3), .tx_bit(txb3), .tx_valido(txv3),
    .tx_inicio(txi3), .tx_fin(txf3)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder written from the bit-equation definition
  function automatic logic [7:0] enc(input logic [3:0] d, input logic s,
                                     input logic db, input logic [2:0] p);
    logic [7:0] w;
    logic [7:0] m;
    logic [2:0] p2;
    w = 8'h00;
    w[3] = d[0]; w[5] = d[1]; w[6] = d[2]; w[7] = d[3];
    w[1] = w[3] ^ w[5] ^ w[7];
    w[2] = w[3] ^ w[6] ^ w[7];
    w[4] = w[5] ^ w[6] ^ w[7];
    w[0] = ^w[7:1];
    m  = 8'h00;
    p2 = p + 3'd1;
    if (db) begin
      m[p]  = 1'b1;
      m[p2] = 1'b1;
    end else if (s) begin
      m[p] = 1'b1;
    end
    return w ^ m;
  endfunction

  // SECDED receiver model: returns {doble, simple, data}
  function automatic logic [5:0] decod(input logic [7:0] w);
    logic [2:0] sind;
    logic       g;
    logic [7:0] c;
    logic       fs;
    logic       fd;
    sind = {w[4]^w[5]^w[6]^w[7], w[2]^w[3]^w[6]^w[7], w[1]^w[3]^w[5]^w[7]};
    g    = ^w;
    c    = w;
    fs   = 1'b0;
    fd   = 1'b0;
    if (g) begin
      fs = 1'b1;
      c[sind] = ~c[sind];
    end else if (sind != 3'd0) begin
      fd = 1'b1;
    end
    return {fd, fs, c[7], c[6], c[5], c[3]};
  endfunction

  // Serial monitor: rebuilds each frame, checks timing, pops the scoreboard
  always @(negedge reloj) begin
    for (int d = 0; d < 2; d++) begin
      logic       v, b, ini, fn, ls;
      logic [7:0] pw;
      logic [7:0] exp;
      int         c;
      int         idx;
      v   = (d == 0) ? txv1 : txv3;
      b   = (d == 0) ? txb1 : txb3;
      ini = (d == 0) ? txi1 : txi3;
      fn  = (d == 0) ? txf1 : txf3;
      ls  = (d == 0) ? listo1 : listo3;
      pw  = (d == 0) ? palabra1 : palabra3;
      c   = (d == 0) ? 1 : 3;
      if (reset) begin
        m_cnt[d]  = 0;
        m_finp[d] = 1'b0;
        m_gap[d]  = 1'b0;
      end else if (v) begin
        idx = m_cnt[d] / c;
        chk("tx_inicio_frame", 8'(ini), 8'(idx == 0));
        chk("tx_fin_in_frame", 8'(fn), 8'd0);
        if (m_cnt[d] % c == 0) m_word[d][idx] = b;
        else chk("tx_bit_hold", 8'(b), 8'(m_word[d][idx]));
        m_cnt[d]++;
        if (m_cnt[d] == 8 * c) begin
          exp = 8'h00;
          if (d == 0) begin
            chk("sb_nonempty1", 8'(q1.size() != 0), 8'd1);
            if (q1.size() != 0) exp = q1.pop_front();
          end else begin
            chk("sb_nonempty3", 8'(q3.size() != 0), 8'd1);
            if (q3.size() != 0) exp = q3.pop_front();
          end
          chk("serial_word", m_word[d], exp);
          chk("palabra_held", pw, exp);
          m_cnt[d]  = 0;
          m_finp[d] = 1'b1;
        end
      end else begin
        chk("frame_len", 8'(m_cnt[d]), 8'd0);
        chk("tx_bit_idle", 8'(b), 8'd0);
        chk("tx_inicio_idle", 8'(ini), 8'd0);
        if (m_finp[d]) begin
          chk("tx_fin_pulse", 8'(fn), 8'd1);
          chk("listo_in_fin", 8'(ls), 8'd0);
          m_finp[d] = 1'b0;
          m_gap[d]  = 1'b1;
        end else begin
          chk("tx_fin_idle", 8'(fn), 8'd0);
          if (m_gap[d]) begin
            chk("listo_after_fin", 8'(ls), 8'd1);
            m_gap[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_listo1", 8'(listo1), 8'd1);
    chk("rst_palabra1", palabra1, 8'h00);
    chk("rst_tx1", {4'd0, txb1, txv1, txi1, txf1}, 8'd0);
    chk("rst_listo3", 8'(listo3), 8'd1);
    chk("rst_palabra3", palabra3, 8'h00);
    chk("rst_tx3", {4'd0, txb3, txv3, txi3, txf3}, 8'd0);
  endtask

  task automatic wait_listo();
    int k;
    k = 0;
    @(negedge reloj);
    while (!(listo1 && listo3) && k < 200) begin
      @(negedge reloj);
      k++;
    end
    chk("listo_timeout", 8'(listo1 && listo3), 8'd1);
  endtask

  task automatic send(input logic [3:0] d, input logic s, input logic db, input logic [2:0] p);
    logic [7:0] e;
    wait_listo();
    e           = enc(d, s, db, p);
    dato        = d;
    iny_s       = s;
    iny_d       = db;
    pos         = p;
    dato_valido = 1'b1;
    q1.push_back(e);
    q3.push_back(e);
    @(posedge reloj);
    #1;
    chk("palabra1_load", palabra1, e);
    chk("palabra3_load", palabra3, e);
    chk("latency_valid1", {6'd0, txv1, txb1}, {6'd0, 1'b1, e[0]});
    @(negedge reloj);
    dato_valido = 1'b0;
    iny_s       = 1'b0;
    iny_d       = 1'b0;
  endtask

  initial begin
    logic [5:0] r;
    reset       = 1'b1;
    dato        = 4'h0;
    dato_valido = 1'b0;
    iny_s       = 1'b0;
    iny_d       = 1'b0;
    pos         = 3'd0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_word[i] = 8'h00; m_finp[i] = 1'b0; m_gap[i] = 1'b0;
    end
    @(posedge reloj);
    @(posedge reloj);
    #1;
    check_reset_vals();
    @(negedge reloj);
    reset = 1'b0;

    // Reference vectors
    send(4'b1011, 1'b0, 1'b0, 3'd0);
    chk("vec_AA", palabra1, 8'hAA);
    send(4'h0, 1'b0, 1'b0, 3'd0);
    chk("vec_00", palabra1, 8'h00);
    send(4'hF, 1'b0, 1'b0, 3'd0);
    chk("vec_FF", palabra1, 8'hFF);
    send(4'b1011, 1'b1, 1'b0, 3'd2);
    chk("vec_AE", palabra1, 8'hAE);
    send(4'h0, 1'b0, 1'b1, 3'd7);
    chk("vec_81_wrap", palabra3, 8'h81);

    // Inputs churned while a frame is in flight
    send(4'h5, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 20; i++) begin
      dato  = 4'($urandom_range(0, 15));
      iny_s = 1'($urandom_range(0, 1));
      iny_d = 1'($urandom_range(0, 1));
      pos   = 3'($urandom_range(0, 7));
      @(negedge reloj);
    end
    iny_s = 1'b0;
    iny_d = 1'b0;

    // Loopback through the SECDED receiver model
    for (int n = 0; n < 16; n++) begin
      for (int md = 0; md < 3; md++) begin
        send(4'(n), 1'(md == 1), 1'(md == 2), 3'($urandom_range(0, 7)));
        r = decod(palabra1);
        if (md == 2) begin
          chk("loop_doble_flag", 8'(r[5:4]), 8'b10);
        end else begin
          chk("loop_data", 8'(r[3:0]), 8'(n));
          chk("loop_simple_flag", 8'(r[5:4]), (md == 1) ? 8'b01 : 8'b00);
        end
      end
    end

    // Reset during bit 4 of a frame, then immediate new acceptance
    send(4'h9, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge reloj);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals();
    q1.delete();
    q3.delete();
    @(negedge reloj);
    @(negedge reloj);
    reset       = 1'b0;
    dato        = 4'b1011;
    dato_valido = 1'b1;
    q1.push_back(8'hAA);
    q3.push_back(8'hAA);
    @(posedge reloj);
    #1;
    chk("post_rst_accept1", {6'd0, txv1, txi1}, 8'b11);
    chk("post_rst_palabra3", palabra3, 8'hAA);
    @(negedge reloj);
    dato_valido = 1'b0;

    wait_listo();
    repeat (3) @(negedge reloj);
    chk("sb_drained", 8'(q1.size() + q3.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
